waterfall_demux_shifter: RTL

- Sequential LED waterfall engine for the FPGA waterfall board.
- Divides the system clock down to a step tick and, on each tick, moves an 8-bit pattern left or right by one bit, using either rotate or shift-with-reload.
- Routes the registered pattern to one of two LED banks: a 1-to-2 demultiplexer, the inverse of the 2-to-1 byte mux already in the design.
- Sits between the board clock/switch inputs and the LED pins.

---
 rtl/waterfall_pkg.sv | 13 +
 rtl/waterfall_demux_shifter_if.sv | 18 +
 rtl/tick_prescaler.sv | 24 ++
 rtl/waterfall_demux_shifter.sv | 58 +++++
 4 files changed

// File: rtl/waterfall_pkg.sv
// waterfall_pkg: shared constants for the LED waterfall engine
//   DIR_*  : step direction encoding (left = toward MSB)
//   MODE_* : rotate or shift-with-reload
//   DEF_*  : default pattern width and seed; SIM_DIV is the short prescale used in simulation
package waterfall_pkg;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam logic [7:0] DEF_SEED = 8'b0000_0001;
  localparam int SIM_DIV = 4;
endpackage

// File: rtl/waterfall_demux_shifter_if.sv
// waterfall_demux_shifter_if: control inputs and LED/status outputs of the waterfall engine
//   en, dir, mode, load, load_val, bank_sel : controls driven by the master
//   led0, led1, pat, tick, lap              : registered outputs driven by the engine (slave)
interface waterfall_demux_shifter_if #(parameter int WIDTH = 8) ();
  logic en;
  logic dir;
  logic mode;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic bank_sel;
  logic [WIDTH-1:0] led0;
  logic [WIDTH-1:0] led1;
  logic [WIDTH-1:0] pat;
  logic tick;
  logic lap;
  modport master (output en, dir, mode, load, load_val, bank_sel, input led0, led1, pat, tick, lap);
  modport slave (input en, dir, mode, load, load_val, bank_sel, output led0, led1, pat, tick, lap);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by DIV into a one-cycle step strobe
//   clk, rst : clock and asynchronous active-high reset
//   en       : count enable; the count holds while low
//   clr      : synchronous clear, wins over counting and masks the strobe
//   tick     : high during the last cycle of each DIV-cycle period
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  // Combinational so the consumer can act on the same edge it registers its own pulse.
  assign tick = en && !clr && cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/waterfall_demux_shifter.sv
// waterfall_demux_shifter: stepped LED pattern (rotate or shift-with-reload) demuxed onto two banks
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of waterfall_demux_shifter_if (controls in; led0/led1/pat/tick/lap out)
import waterfall_pkg::*;
module waterfall_demux_shifter #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV = 50_000_000,
  parameter logic [WIDTH-1:0] SEED = DEF_SEED
) (
  input logic clk,
  input logic rst,
  waterfall_demux_shifter_if.slave bus
);
  logic step;
  logic [WIDTH-1:0] pat_q, nxt, rot, sh, led0_q, led1_q;
  logic tick_q, lap_q;
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction
  // load doubles as the prescaler clear, so a load both restarts the period and masks a coinciding step.
  tick_prescaler #(.DIV(DIV)) u_pre (
    .clk(clk),
    .rst(rst),
    .en(bus.en),
    .clr(bus.load),
    .tick(step)
  );
  // Shift mode refills from the end the pattern is moving away from, hence the reversed seed going right.
  always_comb begin
    rot = bus.dir == DIR_RIGHT ? {pat_q[0], pat_q[WIDTH-1:1]} : {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
    sh = bus.dir == DIR_RIGHT ? pat_q >> 1 : pat_q << 1;
    nxt = bus.mode == MODE_ROT ? rot : |sh ? sh : bus.dir == DIR_RIGHT ? rev(SEED) : SEED;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pat_q <= SEED;
      led0_q <= '0;
      led1_q <= '0;
      tick_q <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      tick_q <= step;
      lap_q <= step && nxt == SEED;
      if (bus.load) pat_q <= bus.load_val;
      else if (step) pat_q <= nxt;
      if (bus.en) begin
        led0_q <= bus.bank_sel ? '0 : pat_q;
        led1_q <= bus.bank_sel ? pat_q : '0;
      end
    end
  assign bus.pat = pat_q;
  assign bus.led0 = led0_q;
  assign bus.led1 = led1_q;
  assign bus.tick = tick_q;
  assign bus.lap = lap_q;
endmodule
